// File: rtl/sram_1rw1r_mask_model.sv
// Behavioural 1RW + 1R SRAM with per-segment write mask, 1- or 2-cycle read latency,
// hold-last-value outputs, registered same-address collision flag and synchronous reset
// of the output/pipeline state (memory contents survive reset).
// Optional feature macro: SRAM_PARITY_EN adds per-segment even parity plus perr0/perr1.
module sram_1rw1r_mask_model #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int unsigned WMASK_WIDTH  = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned VERBOSE      = 0
) (
    input  logic                   clk0,
    input  logic                   rst0,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   collision
`ifdef SRAM_PARITY_EN
    ,
    output logic                   perr0,
    output logic                   perr1
`endif
);

    localparam int unsigned SEG = DATA_WIDTH / WMASK_WIDTH;
    // One extra bit so RAM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  in_rng0, in_rng1, wr_en, rd0_en, rd1_en, collision_d;
    logic [DATA_WIDTH-1:0] rd0_data, rd1_data;
    logic                  p0_vld_q, p1_vld_q;
    logic [DATA_WIDTH-1:0] p0_dat_q, p1_dat_q;
    logic [DATA_WIDTH-1:0] dout0_d, dout0_q, dout1_d, dout1_q;
    logic                  collision_q;

    // Decode this cycle's accesses; reset suppresses both ports.
    always_comb begin
        in_rng0     = {1'b0, addr0} < DEPTH;
        in_rng1     = {1'b0, addr1} < DEPTH;
        wr_en       = !rst0 && !csb0 && !web0 && in_rng0;
        rd0_en      = !rst0 && !csb0 && web0;
        rd1_en      = !rst0 && !csb1;
        rd0_data    = in_rng0 ? mem[addr0] : '0;
        rd1_data    = in_rng1 ? mem[addr1] : '0;
        collision_d = wr_en && (|wmask0) && rd1_en && in_rng1 && (addr0 == addr1);
    end

    // Masked write; reads above sample the pre-edge word, giving read-before-write.
    always_ff @(posedge clk0) begin
        if (wr_en) begin
            for (int i = 0; i < int'(WMASK_WIDTH); i++) begin
                if (wmask0[i]) mem[addr0][i*SEG +: SEG] <= din0[i*SEG +: SEG];
            end
        end
    end

    // Select the value each dout takes next: direct read or the delayed pipeline stage.
    always_comb begin
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        if (READ_LATENCY == 1) begin
            if (rd0_en) dout0_d = rd0_data;
            if (rd1_en) dout1_d = rd1_data;
        end else begin
            if (p0_vld_q) dout0_d = p0_dat_q;
            if (p1_vld_q) dout1_d = p1_dat_q;
        end
    end

    // Output and pipeline registers; reset discards in-flight reads.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            p0_vld_q    <= 1'b0;
            p1_vld_q    <= 1'b0;
            p0_dat_q    <= '0;
            p1_dat_q    <= '0;
            dout0_q     <= '0;
            dout1_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            p0_vld_q    <= rd0_en;
            p1_vld_q    <= rd1_en;
            p0_dat_q    <= rd0_data;
            p1_dat_q    <= rd1_data;
            dout0_q     <= dout0_d;
            dout1_q     <= dout1_d;
            collision_q <= collision_d;
        end
    end

    assign dout0     = dout0_q;
    assign dout1     = dout1_q;
    assign collision = collision_q;

`ifdef SRAM_PARITY_EN
    logic [WMASK_WIDTH-1:0] par [RAM_DEPTH];
    logic                   rd0_perr, rd1_perr, pp0_q, pp1_q, perr0_q, perr1_q;

    // Recompute segment parity on read and compare with the stored bits.
    always_comb begin
        rd0_perr = 1'b0;
        rd1_perr = 1'b0;
        for (int i = 0; i < int'(WMASK_WIDTH); i++) begin
            if (in_rng0 && ((^rd0_data[i*SEG +: SEG]) != par[addr0][i])) rd0_perr = 1'b1;
            if (in_rng1 && ((^rd1_data[i*SEG +: SEG]) != par[addr1][i])) rd1_perr = 1'b1;
        end
    end

    // Parity bits follow the data write mask.
    always_ff @(posedge clk0) begin
        if (wr_en) begin
            for (int i = 0; i < int'(WMASK_WIDTH); i++) begin
                if (wmask0[i]) par[addr0][i] <= ^din0[i*SEG +: SEG];
            end
        end
    end

    // Error flags move in lockstep with the dout they qualify.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            pp0_q   <= 1'b0;
            pp1_q   <= 1'b0;
            perr0_q <= 1'b0;
            perr1_q <= 1'b0;
        end else begin
            pp0_q <= rd0_perr;
            pp1_q <= rd1_perr;
            if (READ_LATENCY == 1) begin
                if (rd0_en) perr0_q <= rd0_perr;
                if (rd1_en) perr1_q <= rd1_perr;
            end else begin
                if (p0_vld_q) perr0_q <= pp0_q;
                if (p1_vld_q) perr1_q <= pp1_q;
            end
        end
    end

    assign perr0 = perr0_q;
    assign perr1 = perr1_q;

    task automatic inject_parity_error(input int unsigned addr, input int unsigned seg);
        par[addr][seg] <= ~par[addr][seg];
    endtask
`endif

`ifndef SYNTHESIS
    if (VERBOSE != 0) begin : g_verbose
        // Access trace for debugging.
        always @(posedge clk0) begin
            if (wr_en)  $display("%0t sram p0 wr addr=%h data=%h mask=%b", $time, addr0, din0, wmask0);
            if (rd0_en) $display("%0t sram p0 rd addr=%h data=%h", $time, addr0, rd0_data);
            if (rd1_en) $display("%0t sram p1 rd addr=%h data=%h", $time, addr1, rd1_data);
        end
    end
`endif

endmodule

// File: tb/tb_sram_1rw1r_mask_model.sv
// Scoreboard bench: two instances share stimulus (A: latency 1, full depth; B: latency 2,
// depth 300). Stimulus pushes hand-computed expectations tagged with a due cycle; a monitor
// on the falling edge pops and compares them.
module tb_sram_1rw1r_mask_model;

    logic        clk = 1'b0;
    logic        rst0, csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [8:0]  addr0, addr1;
    logic [31:0] din0;
    logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
    logic        a_col, b_col;

    always #5 clk = ~clk;

    sram_1rw1r_mask_model #(.READ_LATENCY(1)) u_a (
        .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(a_dout0), .csb1(csb1), .addr1(addr1), .dout1(a_dout1),
        .collision(a_col)
    );

    sram_1rw1r_mask_model #(.RAM_DEPTH(300), .READ_LATENCY(2)) u_b (
        .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(b_dout0), .csb1(csb1), .addr1(addr1), .dout1(b_dout1),
        .collision(b_col)
    );

    typedef struct {
        int          due;
        int          dut;   // 0 = A, 1 = B
        int          kind;  // 0 = dout0, 1 = dout1, 2 = collision
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int dut, input int kind);
        case (kind)
            0:       return (dut == 0) ? a_dout0 : b_dout0;
            1:       return (dut == 0) ? a_dout1 : b_dout1;
            default: return {31'd0, (dut == 0) ? a_col : b_col};
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            0:       return "dout0";
            1:       return "dout1";
            default: return "collision";
        endcase
    endfunction

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        int i;
        logic [31:0] got;
        i = 0;
        while (i < q.size()) begin
            if (q[i].due == cyc) begin
                got = actual(q[i].dut, q[i].kind);
                checks = checks + 1;
                if (got !== q[i].val) begin
                    errors = errors + 1;
                    $display("FAIL %s dut=%s cycle=%0d got=%h expected=%h", kname(q[i].kind),
                             (q[i].dut == 0) ? "A" : "B", cyc, got, q[i].val);
                end
                q.delete(i);
            end else if (q[i].due < cyc) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL %s dut=%0d missed due cycle %0d got=none expected=%h",
                         kname(q[i].kind), q[i].dut, q[i].due, q[i].val);
                q.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    task automatic push(input int dut, input int kind, input int off, input logic [31:0] v);
        exp_t e;
        e.due  = cyc + off;
        e.dut  = dut;
        e.kind = kind;
        e.val  = v;
        q.push_back(e);
    endtask

    // Read result on both instances: A after 1 cycle, B after 2.
    task automatic push_rd(input int kind, input logic [31:0] va, input logic [31:0] vb);
        push(0, kind, 1, va);
        push(1, kind, 2, vb);
    endtask

    task automatic push_col(input logic ca, input logic cb);
        push(0, 2, 1, {31'd0, ca});
        push(1, 2, 1, {31'd0, cb});
    endtask

    task automatic drive(input logic c0, input logic w0, input logic [3:0] m0,
                         input logic [8:0] a0, input logic [31:0] d0,
                         input logic c1, input logic [8:0] a1);
        csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 4'h0, 9'd0, 32'h0, 1'b1, 9'd0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst0 = 1'b1;
        idle();
        tick();
        tick();
        // Reset state.
        rst0 = 1'b0;
        for (int d = 0; d < 2; d++) for (int k = 0; k < 3; k++) push(d, k, 1, 32'h0);
        tick();
        // Full write then port-1 read.
        drive(0, 0, 4'hF, 9'd5, 32'hDEADBEEF, 1, 9'd0);
        push_col(0, 0);
        push(0, 0, 1, 32'h0);  // dout0 holds across a write
        tick();
        drive(1, 1, 4'h0, 9'd0, 32'h0, 0, 9'd5);
        push_rd(1, 32'hDEADBEEF, 32'hDEADBEEF);
        tick();
        // Masked write.
        drive(0, 0, 4'hF, 9'd7, 32'h11223344, 1, 9'd0);
        tick();
        drive(0, 0, 4'b0101, 9'd7, 32'hAABBCCDD, 1, 9'd0);
        tick();
        drive(0, 1, 4'h0, 9'd7, 32'h0, 1, 9'd0);
        push_rd(0, 32'h11BB33DD, 32'h11BB33DD);
        tick();
        drive(0, 0, 4'hF, 9'd9, 32'h0, 1, 9'd0);
        push(0, 0, 1, 32'h11BB33DD);
        push(1, 0, 2, 32'h11BB33DD);
        tick();
        // Collision: read-before-write, one-cycle flag.
        drive(0, 0, 4'hF, 9'd9, 32'hFFFF0000, 0, 9'd9);
        push_col(1, 1);
        push_rd(1, 32'h0, 32'h0);
        tick();
        drive(1, 1, 4'h0, 9'd0, 32'h0, 0, 9'd9);
        push_col(0, 0);
        push_rd(1, 32'hFFFF0000, 32'hFFFF0000);
        tick();
        // Mask-0 write does not flag and changes nothing.
        drive(0, 0, 4'h0, 9'd9, 32'h12345678, 0, 9'd9);
        push_col(0, 0);
        push_rd(1, 32'hFFFF0000, 32'hFFFF0000);
        tick();
        // Two reads of one address never flag.
        drive(0, 1, 4'h0, 9'd5, 32'h0, 0, 9'd5);
        push_col(0, 0);
        push_rd(0, 32'hDEADBEEF, 32'hDEADBEEF);
        push_rd(1, 32'hDEADBEEF, 32'hDEADBEEF);
        tick();
        // Latency / pipelining / hold.
        drive(0, 0, 4'hF, 9'd1, 32'h11110001, 1, 9'd0);
        tick();
        drive(0, 0, 4'hF, 9'd2, 32'h22220002, 1, 9'd0);
        tick();
        drive(0, 0, 4'hF, 9'd3, 32'h33330003, 1, 9'd0);
        tick();
        drive(1, 1, 4'h0, 9'd0, 32'h0, 0, 9'd1);
        push_rd(1, 32'h11110001, 32'h11110001);
        push(1, 1, 1, 32'hDEADBEEF);  // B has not updated yet after one cycle
        tick();
        drive(1, 1, 4'h0, 9'd0, 32'h0, 0, 9'd2);
        push_rd(1, 32'h22220002, 32'h22220002);
        tick();
        drive(1, 1, 4'h0, 9'd0, 32'h0, 0, 9'd3);
        push_rd(1, 32'h33330003, 32'h33330003);
        tick();
        idle();
        for (int o = 1; o <= 3; o++) begin
            push(0, 1, o, 32'h33330003);
            push(1, 1, o, 32'h33330003);
        end
        tick();
        tick();
        tick();
        // Reset with a read in flight; writes during reset are ignored.
        drive(1, 1, 4'h0, 9'd0, 32'h0, 0, 9'd2);
        push(0, 1, 1, 32'h22220002);
        tick();
        rst0 = 1'b1;
        drive(0, 0, 4'hF, 9'd7, 32'h0, 0, 9'd3);
        for (int d = 0; d < 2; d++) for (int k = 0; k < 3; k++) push(d, k, 1, 32'h0);
        tick();
        rst0 = 1'b0;
        idle();
        push(0, 1, 1, 32'h0);
        push(1, 1, 1, 32'h0);
        push(1, 1, 2, 32'h0);
        tick();
        drive(0, 1, 4'h0, 9'd7, 32'h0, 0, 9'd2);
        push_rd(0, 32'h11BB33DD, 32'h11BB33DD);
        push_rd(1, 32'h22220002, 32'h22220002);
        tick();
        // Out of range on B (depth 300); address 400 is valid on A.
        drive(0, 0, 4'hF, 9'd400, 32'hCAFEF00D, 1, 9'd0);
        tick();
        drive(0, 0, 4'hF, 9'd299, 32'h0BADC0DE, 1, 9'd0);
        tick();
        drive(0, 1, 4'h0, 9'd299, 32'h0, 0, 9'd400);
        push_rd(1, 32'hCAFEF00D, 32'h0);
        push_rd(0, 32'h0BADC0DE, 32'h0BADC0DE);
        tick();
        drive(0, 0, 4'hF, 9'd400, 32'h12345678, 0, 9'd400);
        push_col(1, 0);
        push_rd(1, 32'hCAFEF00D, 32'h0);
        tick();
        drive(1, 1, 4'h0, 9'd0, 32'h0, 0, 9'd299);
        push_col(0, 0);
        push_rd(1, 32'h0BADC0DE, 32'h0BADC0DE);
        tick();
        idle();
        repeat (6) tick();
        // Anything still queued was never compared.
        while (q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s dut=%0d unchecked at end got=none expected=%h",
                     kname(q[0].kind), q[0].dut, q[0].val);
            q.delete(0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
